eu_rd_arbiter: RTL and testbench

//  Shares one execution unit's interconnect read port (raddr/rvalid -> rdata/rsuccess) between NUM_REQ requesters.

---
 rtl/eu_rd_arbiter_pkg.sv | 25 ++
 rtl/eu_rd_arbiter_rr_pick.sv | 31 +++
 rtl/eu_rd_arbiter.sv | 157 +++++++++++++++
 tb/tb_eu_rd_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/eu_rd_arbiter_pkg.sv
// Shared types and helpers for the EU read-port arbiter.
// Provides the default requester count (overridable with `EU_RD_ARB_NUM_REQ).
`ifndef EU_RD_ARB_NUM_REQ
`define EU_RD_ARB_NUM_REQ 4
`endif

package eu_rd_arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_ISSUE} type_eu_rd_arb_state;

    localparam int EXEC_UNIT_ADDR_W = 16;
    localparam int EXEC_UNIT_DATA_W = 32;

    typedef logic [EXEC_UNIT_ADDR_W-1:0] type_exec_unit_addr;
    typedef logic [EXEC_UNIT_DATA_W-1:0] type_exec_unit_data;

    localparam int EU_RD_ARB_NUM_REQ_DFLT = `EU_RD_ARB_NUM_REQ;

    localparam int STAT_W = 32;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/eu_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible (req & ~mask) index
// at or after ptr, wrapping modulo NUM_REQ.
module eu_rd_arbiter_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ-1:0]         i_mask,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic                       o_found,
    output logic [$clog2(NUM_REQ)-1:0] o_idx
);

    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] w_elig;

    assign w_elig = i_req & ~i_mask;

    // Walk from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_elig[IW'((int'(i_ptr) + k) % NUM_REQ)]) begin
                o_found = 1'b1;
                o_idx   = IW'((int'(i_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/eu_rd_arbiter.sv
// Round-robin arbiter sharing one EU interconnect read port between NUM_REQ requesters,
// with a retry cap. `EU_RD_ARB_STATS_EN adds saturating grant/retry/release counters.
//
//  state     | meaning
//  ARB_IDLE  | no owner; pick a winner from rr_ptr, grant it next cycle
//  ARB_ISSUE | owner drives the EU read; success, retry cap or cancel ends it
module eu_rd_arbiter
    import eu_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = EU_RD_ARB_NUM_REQ_DFLT,
    parameter int MAX_RETRY = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  type_exec_unit_addr req_addr_i [NUM_REQ],
    output logic [NUM_REQ-1:0] grant_o,
    output type_exec_unit_data rdata_o,
    output logic [NUM_REQ-1:0] rsuccess_o,
    output type_exec_unit_addr eu_raddr_o,
    output logic               eu_rvalid_o,
    input  type_exec_unit_data eu_rdata_i,
    input  logic               eu_rsuccess_i
`ifdef EU_RD_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]  stat_grants_o,
    output logic [STAT_W-1:0]  stat_retries_o,
    output logic [STAT_W-1:0]  stat_releases_o
`endif
);

    localparam int              IW         = $clog2(NUM_REQ);
    localparam int              CW         = $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0]   RETRY_LAST = CW'(MAX_RETRY - 1);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(NUM_REQ - 1);

    type_eu_rd_arb_state r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [IW-1:0]       r_owner;
    logic [IW-1:0]       r_rr_ptr;
    type_exec_unit_addr  r_addr;
    logic [CW-1:0]       r_retry_cnt;

    logic          w_issue;
    logic          w_owner_req;
    logic          w_success;
    logic          w_fail;
    logic          w_release;
    logic          w_pick_found;
    logic [IW-1:0] w_pick_idx;
    logic [IW-1:0] w_pick_ptr;
    logic [IW-1:0] w_owner_next;

    assign w_issue      = (r_state == ARB_ISSUE);
    assign w_owner_req  = req_valid_i[r_owner];
    // Gating with reset_n keeps a read issued during reset from reporting success.
    assign eu_rvalid_o  = w_issue & w_owner_req & reset_n;
    assign w_success    = eu_rvalid_o & eu_rsuccess_i;
    assign w_fail       = eu_rvalid_o & ~eu_rsuccess_i;
    assign w_release    = w_fail & (r_retry_cnt == RETRY_LAST);
    assign w_owner_next = (r_owner == IDX_LAST) ? '0 : r_owner + 1'b1;
    assign w_pick_ptr   = w_issue ? w_owner_next : r_rr_ptr;

    assign grant_o    = r_grant;
    assign rsuccess_o = r_grant & {NUM_REQ{w_success}};
    assign eu_raddr_o = w_issue ? r_addr : '0;
    assign rdata_o    = eu_rdata_i;

    // r_grant is zero in IDLE, so masking with it only affects the back-to-back pick.
    eu_rd_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req   (req_valid_i),
        .i_mask  (r_grant),
        .i_ptr   (w_pick_ptr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ARB_IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_addr      <= '0;
            r_retry_cnt <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_found) begin
                        r_state <= ARB_ISSUE;
                        r_grant <= NUM_REQ'(1) << w_pick_idx;
                        r_owner <= w_pick_idx;
                        r_addr  <= req_addr_i[w_pick_idx];
                    end
                end
                ARB_ISSUE: begin
                    if (w_success) begin
                        r_rr_ptr    <= w_owner_next;
                        r_retry_cnt <= '0;
                        if (w_pick_found) begin
                            r_grant <= NUM_REQ'(1) << w_pick_idx;
                            r_owner <= w_pick_idx;
                            r_addr  <= req_addr_i[w_pick_idx];
                        end else begin
                            r_state <= ARB_IDLE;
                            r_grant <= '0;
                        end
                    end else if (!w_owner_req) begin
                        r_state     <= ARB_IDLE;
                        r_grant     <= '0;
                        r_retry_cnt <= '0;
                    end else if (w_release) begin
                        r_state     <= ARB_IDLE;
                        r_grant     <= '0;
                        r_rr_ptr    <= w_owner_next;
                        r_retry_cnt <= '0;
                    end else begin
                        r_retry_cnt <= r_retry_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

`ifdef EU_RD_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_grants;
    logic [STAT_W-1:0] r_stat_retries;
    logic [STAT_W-1:0] r_stat_releases;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stat_grants   <= '0;
            r_stat_retries  <= '0;
            r_stat_releases <= '0;
        end else begin
            if (w_success) r_stat_grants   <= sat_inc(r_stat_grants);
            if (w_fail)    r_stat_retries  <= sat_inc(r_stat_retries);
            if (w_release) r_stat_releases <= sat_inc(r_stat_releases);
        end
    end

    assign stat_grants_o   = r_stat_grants;
    assign stat_retries_o  = r_stat_retries;
    assign stat_releases_o = r_stat_releases;
`endif

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant_o));
    a_rvalid_owned:  assert property (@(posedge clk) disable iff (!reset_n) eu_rvalid_o |-> (|grant_o));
    a_rsucc_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(rsuccess_o));

endmodule

// File: tb/tb_eu_rd_arbiter.sv
// Directed bench for eu_rd_arbiter: stimulus pushes expected issue cycles into a queue,
// a negedge monitor pops and compares whenever eu_rvalid_o is high.
module tb_eu_rd_arbiter;
    import eu_rd_arbiter_pkg::*;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [N-1:0]       req_valid_i;
    type_exec_unit_addr req_addr_i [N];
    logic [N-1:0]       grant_o;
    type_exec_unit_data rdata_o;
    logic [N-1:0]       rsuccess_o;
    type_exec_unit_addr eu_raddr_o;
    logic               eu_rvalid_o;
    type_exec_unit_data eu_rdata_i;
    logic               eu_rsuccess_i;
    logic               eu_ok;
`ifdef EU_RD_ARB_STATS_EN
    logic [31:0]        stat_grants_o, stat_retries_o, stat_releases_o;
`endif

    typedef struct {
        logic [N-1:0]       grant;
        type_exec_unit_addr addr;
        logic [N-1:0]       succ;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam type_exec_unit_addr A0 = 16'h1000;
    localparam type_exec_unit_addr A1 = 16'h2001;
    localparam type_exec_unit_addr A2 = 16'h3002;
    localparam type_exec_unit_addr A3 = 16'h4003;

    always #5 clk = ~clk;

    // Simple EU model: data is a tag plus the address being read.
    assign eu_rdata_i    = {16'hDA7A, eu_raddr_o};
    assign eu_rsuccess_i = eu_ok;

    eu_rd_arbiter #(.NUM_REQ(N), .MAX_RETRY(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid_i    (req_valid_i),
        .req_addr_i     (req_addr_i),
        .grant_o        (grant_o),
        .rdata_o        (rdata_o),
        .rsuccess_o     (rsuccess_o),
        .eu_raddr_o     (eu_raddr_o),
        .eu_rvalid_o    (eu_rvalid_o),
        .eu_rdata_i     (eu_rdata_i),
        .eu_rsuccess_i  (eu_rsuccess_i)
`ifdef EU_RD_ARB_STATS_EN
        ,
        .stat_grants_o  (stat_grants_o),
        .stat_retries_o (stat_retries_o),
        .stat_releases_o(stat_releases_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] g, input type_exec_unit_addr a, input logic [N-1:0] s);
        exp_t e;
        e.grant = g;
        e.addr  = a;
        e.succ  = s;
        exp_q.push_back(e);
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        chk({tag, "_grant"},  32'(grant_o),     32'h0);
        chk({tag, "_rvalid"}, 32'(eu_rvalid_o), 32'h0);
        chk({tag, "_rsucc"},  32'(rsuccess_o),  32'h0);
    endtask

    always @(negedge clk) begin
        if (eu_rvalid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue grant=%b raddr=%h", grant_o, eu_raddr_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_grant", 32'(grant_o),    32'(e.grant));
                chk("mon_raddr", 32'(eu_raddr_o), 32'(e.addr));
                chk("mon_rsucc", 32'(rsuccess_o), 32'(e.succ));
                if (e.succ != '0) chk("mon_rdata", rdata_o, {16'hDA7A, e.addr});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        req_valid_i   = '0;
        eu_ok         = 1'b0;
        req_addr_i[0] = A0;
        req_addr_i[1] = A1;
        req_addr_i[2] = A2;
        req_addr_i[3] = A3;
        repeat (3) step();
        @(negedge clk);
        chk("rst_grant",  32'(grant_o),     32'h0);
        chk("rst_rvalid", 32'(eu_rvalid_o), 32'h0);
        chk("rst_raddr",  32'(eu_raddr_o),  32'h0);
        chk("rst_rsucc",  32'(rsuccess_o),  32'h0);
`ifdef EU_RD_ARB_STATS_EN
        chk("rst_stat_grants", stat_grants_o, 32'h0);
`endif
        step(); reset_n = 1'b1;

        // 1: single requester, one-cycle bubble then same-cycle success
        step(); req_valid_i = 4'b0001; eu_ok = 1'b1; expect_idle("t1_bubble");
        step(); push(4'b0001, A0, 4'b0001);
        step(); req_valid_i = 4'b0000; expect_idle("t1_done");

        // 2: all four back-to-back from rr_ptr=0
        step(); reset_n = 1'b0;
        step(); reset_n = 1'b1;
        step(); req_valid_i = 4'b1111; expect_idle("t2_bubble");
        step(); push(4'b0001, A0, 4'b0001);
        step(); req_valid_i = 4'b1110; push(4'b0010, A1, 4'b0010);
        step(); req_valid_i = 4'b1100; push(4'b0100, A2, 4'b0100);
        step(); req_valid_i = 4'b1000; push(4'b1000, A3, 4'b1000);
        step(); req_valid_i = 4'b0000; expect_idle("t2_done");

        // 3: req0 fails 8 times, released, req1 then served (also shows rr_ptr was 0)
        step(); req_valid_i = 4'b0011; eu_ok = 1'b0; expect_idle("t3_bubble");
        for (int i = 0; i < 8; i++) begin
            step(); push(4'b0001, A0, 4'b0000);
        end
        step(); expect_idle("t3_release");
        step(); req_valid_i = 4'b0010; eu_ok = 1'b1; push(4'b0010, A1, 4'b0010);
        step(); req_valid_i = 4'b0000; expect_idle("t3_done");

        // 4: req2 cancels mid-retry; success on the cancel cycle is ignored
        step(); req_valid_i = 4'b0100; eu_ok = 1'b0; expect_idle("t4_bubble");
        step(); push(4'b0100, A2, 4'b0000);
        step(); push(4'b0100, A2, 4'b0000);
        step(); req_valid_i = 4'b0000; eu_ok = 1'b1;
        @(negedge clk);
        chk("t4_cancel_grant",  32'(grant_o),     32'h4);
        chk("t4_cancel_rvalid", 32'(eu_rvalid_o), 32'h0);
        chk("t4_cancel_rsucc",  32'(rsuccess_o),  32'h0);
        step(); expect_idle("t4_idle");
        // rr_ptr must still be 2: req2 beats req0
        step(); req_valid_i = 4'b0101; expect_idle("t4_bubble2");
        step(); push(4'b0100, A2, 4'b0100);
        step(); req_valid_i = 4'b0001; push(4'b0001, A0, 4'b0001);
        step(); req_valid_i = 4'b0000; expect_idle("t4_done");

        // 6: reach rr_ptr=3, then 1001 serves req3 then wraps to req0
        step(); req_valid_i = 4'b0100; expect_idle("t6_bubble");
        step(); push(4'b0100, A2, 4'b0100);
        step(); req_valid_i = 4'b0000; expect_idle("t6_idle");
        step(); req_valid_i = 4'b1001; expect_idle("t6_bubble2");
        step(); push(4'b1000, A3, 4'b1000);
        step(); req_valid_i = 4'b0001; push(4'b0001, A0, 4'b0001);
        step(); req_valid_i = 4'b0000; expect_idle("t6_done");

        // 5: reset during ISSUE with success pending
        step(); req_valid_i = 4'b0010; expect_idle("t5_bubble");
        step(); reset_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_cycle_grant",  32'(grant_o),     32'h2);
        chk("t5_rst_cycle_rvalid", 32'(eu_rvalid_o), 32'h0);
        chk("t5_rst_cycle_rsucc",  32'(rsuccess_o),  32'h0);
        step();
        @(negedge clk);
        chk("t5_after_grant",  32'(grant_o),     32'h0);
        chk("t5_after_rvalid", 32'(eu_rvalid_o), 32'h0);
`ifdef EU_RD_ARB_STATS_EN
        chk("t5_stat_grants",   stat_grants_o,   32'h0);
        chk("t5_stat_retries",  stat_retries_o,  32'h0);
        chk("t5_stat_releases", stat_releases_o, 32'h0);
`endif
        step(); reset_n = 1'b1; req_valid_i = 4'b0011; expect_idle("t5_bubble2");
        step(); push(4'b0001, A0, 4'b0001);
        step(); req_valid_i = 4'b0010; push(4'b0010, A1, 4'b0010);
        step(); req_valid_i = 4'b0000; expect_idle("t5_done");

        repeat (3) step();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
